// File: rtl/uart_rx_if.sv
// Serial receive port bundle: the raw serial line in, received byte and status out.
interface uart_rx_if;
   logic       i_RX_Serial;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;
   logic       o_RX_Busy;
   logic       o_Frame_Err;

   modport slave (
      input  i_RX_Serial,
      output o_RX_DV,
      output o_RX_Byte,
      output o_RX_Busy,
      output o_Frame_Err
   );

   modport master (
      output i_RX_Serial,
      input  o_RX_DV,
      input  o_RX_Byte,
      input  o_RX_Busy,
      input  o_Frame_Err
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the line, centre-samples each bit and reports
// a one-cycle valid pulse per good byte or a one-cycle framing-error pulse.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.slave  rx
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

   state_t           state, state_n;
   logic             sync_p0, rx_s;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shift, shift_n;
   logic [7:0]       byte_q, byte_n;
   logic             dv_q, dv_n;
   logic             ferr_q, ferr_n;

   // Stage p0/p1: two-flop synchronizer, idles high
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         sync_p0 <= rx.i_RX_Serial;
         rx_s    <= sync_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         byte_q  <= '0;
         dv_q    <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         byte_q  <= byte_n;
         dv_q    <= dv_n;
         ferr_q  <= ferr_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      byte_n    = byte_q;
      dv_n      = 1'b0;
      ferr_n    = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_n     = '0;
            bit_idx_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            // Mid-start-bit check: a line that has gone high again was a glitch
            if (cnt == CNT_HALF) begin
               cnt_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_n            = '0;
               shift_n[bit_idx] = rx_s;
               bit_idx_n        = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_n = STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_n   = '0;
               state_n = CLEANUP;
               if (rx_s) begin
                  byte_n = shift;
                  dv_n   = 1'b1;
               end else begin
                  ferr_n = 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         CLEANUP: begin
            // A held-low break must release before another start is accepted
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign rx.o_RX_DV     = dv_q;
   assign rx.o_RX_Byte   = byte_q;
   assign rx.o_Frame_Err = ferr_q;
   assign rx.o_RX_Busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame table plus hand-written glitch,
// back-to-back and mid-frame-reset sequences.
module tb_uart_rx;
   localparam int N    = 434;
   localparam int HALF = (N - 1) / 2;
   localparam int LAT  = 2 + HALF + 9 * N;

   logic clk = 1'b0;
   logic rst = 1'b1;
   uart_rx_if ifc();

   uart_rx #(.CLKS_PER_BIT(N)) dut (.clk(clk), .rst(rst), .rx(ifc));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int dv_cnt = 0, ferr_cnt = 0, busy_cnt = 0;
   int overlap = 0, wide = 0, byte_chg = 0;
   int dv_cycs [8];
   logic [7:0] dv_bytes [8];
   logic prev_dv = 1'b0, prev_fe = 1'b0, rst_q = 1'b1;
   logic [7:0] prev_byte = 8'h00;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   always @(negedge clk) begin
      if (ifc.o_RX_DV) begin
         if (dv_cnt < 8) begin
            dv_cycs[dv_cnt]  <= cyc;
            dv_bytes[dv_cnt] <= ifc.o_RX_Byte;
         end
         dv_cnt <= dv_cnt + 1;
      end
      if (ifc.o_Frame_Err) ferr_cnt <= ferr_cnt + 1;
      if (ifc.o_RX_Busy) busy_cnt <= busy_cnt + 1;
      if (ifc.o_RX_DV && ifc.o_Frame_Err) overlap <= overlap + 1;
      if ((ifc.o_RX_DV && prev_dv) || (ifc.o_Frame_Err && prev_fe)) wide <= wide + 1;
      if (ifc.o_RX_Byte !== prev_byte && !ifc.o_RX_DV && !rst_q) byte_chg <= byte_chg + 1;
      prev_dv   <= ifc.o_RX_DV;
      prev_fe   <= ifc.o_Frame_Err;
      prev_byte <= ifc.o_RX_Byte;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // All stimulus tasks start and end #1 after a rising edge
   task automatic idle(input int n);
      ifc.i_RX_Serial = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
      ifc.i_RX_Serial = 1'b0;
      t0 = cyc;
      repeat (N) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         ifc.i_RX_Serial = b[i];
         repeat (N) @(posedge clk);
         #1;
      end
      ifc.i_RX_Serial = stop;
      repeat (N) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         hold_bits;
      int         exp_dv;
      logic [7:0] exp_byte;
      int         exp_ferr;
   } vec_t;

   vec_t vecs [3];

   initial begin
      #20_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, d0, f0, b0;
      logic [7:0] partial;
      vecs[0] = '{8'h0D, 1'b1, 0, 1, 8'h0D, 0};
      vecs[1] = '{8'h4A, 1'b0, 2, 0, 8'h0D, 1};
      vecs[2] = '{8'h54, 1'b1, 0, 1, 8'h54, 0};

      ifc.i_RX_Serial = 1'b1;
      rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("reset_dv", ifc.o_RX_DV, 0);
      check("reset_ferr", ifc.o_Frame_Err, 0);
      check("reset_byte", ifc.o_RX_Byte, 8'h00);
      check("reset_busy", ifc.o_RX_Busy, 0);
      rst = 1'b0;
      idle(4);

      // Frame table: good byte, framing error with held break, recovery byte
      for (int v = 0; v < 3; v++) begin
         d0 = dv_cnt; f0 = ferr_cnt;
         send_frame(vecs[v].data, vecs[v].stop, t0);
         if (vecs[v].hold_bits > 0) begin
            ifc.i_RX_Serial = 1'b0;
            repeat (vecs[v].hold_bits * N) @(posedge clk);
            #1;
         end
         idle(2 * N);
         check($sformatf("tbl%0d_dv", v), dv_cnt - d0, vecs[v].exp_dv);
         check($sformatf("tbl%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
         check($sformatf("tbl%0d_byte", v), ifc.o_RX_Byte, vecs[v].exp_byte);
         check($sformatf("tbl%0d_busy", v), ifc.o_RX_Busy, 0);
         if (vecs[v].exp_dv == 1 && dv_cnt > d0) begin
            check($sformatf("tbl%0d_dv_byte", v), dv_bytes[d0], vecs[v].exp_byte);
            check_range($sformatf("tbl%0d_latency", v), dv_cycs[d0] - t0, LAT - 2, LAT + 2);
         end
      end

      // Start glitch shorter than half a bit
      d0 = dv_cnt; f0 = ferr_cnt; b0 = busy_cnt;
      ifc.i_RX_Serial = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      idle(2 * N);
      check("glitch_busy_seen", (busy_cnt - b0) > 0, 1);
      check("glitch_busy_end", ifc.o_RX_Busy, 0);
      check("glitch_dv", dv_cnt - d0, 0);
      check("glitch_ferr", ferr_cnt - f0, 0);

      // Back-to-back frames with a single stop bit and no gap
      d0 = dv_cnt;
      send_frame(8'h54, 1'b1, t0);
      send_frame(8'h41, 1'b1, t1);
      idle(2 * N);
      check("b2b_count", dv_cnt - d0, 2);
      if (dv_cnt - d0 == 2) begin
         check("b2b_first", dv_bytes[d0], 8'h54);
         check("b2b_second", dv_bytes[d0 + 1], 8'h41);
         check_range("b2b_spacing", dv_cycs[d0 + 1] - dv_cycs[d0], 10 * N - 2, 10 * N + 2);
      end
      check("b2b_last_byte", ifc.o_RX_Byte, 8'h41);

      // Reset pulse in the middle of data bit 3 of 0x4A; sender then goes idle
      d0 = dv_cnt; f0 = ferr_cnt;
      partial = 8'h4A;
      ifc.i_RX_Serial = 1'b0;
      repeat (N) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         ifc.i_RX_Serial = partial[i];
         repeat (N) @(posedge clk);
         #1;
      end
      ifc.i_RX_Serial = partial[3];
      repeat (N / 2) @(posedge clk);
      #1;
      check("midrst_busy_before", ifc.o_RX_Busy, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_busy", ifc.o_RX_Busy, 0);
      check("midrst_byte", ifc.o_RX_Byte, 8'h00);
      idle(12 * N);
      check("midrst_dv", dv_cnt - d0, 0);
      check("midrst_ferr", ferr_cnt - f0, 0);
      check("midrst_byte_after", ifc.o_RX_Byte, 8'h00);

      d0 = dv_cnt;
      send_frame(8'h0D, 1'b1, t0);
      idle(2 * N);
      check("post_rst_dv", dv_cnt - d0, 1);
      check("post_rst_byte", ifc.o_RX_Byte, 8'h0D);

      check("dv_ferr_overlap", overlap, 0);
      check("pulse_width", wide, 0);
      check("byte_hold", byte_chg, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
